// File: rtl/fp_pkg.sv
// Shared IEEE-754 single-precision constants and the sequential multiplier's FSM encoding.
package fp_pkg;

    localparam int EXP_BIAS = 127;
    localparam int EXP_MAX  = 255;
    localparam int EXP_W    = 8;
    localparam int FRAC_W   = 23;
    localparam int MANT_W   = 24;

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        NORM = 2'd2,
        DONE = 2'd3
    } state_e;

endpackage

// File: rtl/fp_mul_special.sv
// Combinational classifier for the multiplier operands: flags NaN/inf/zero operand pairs
// and supplies the fixed result for them. Denormals count as zero.
module fp_mul_special
    import fp_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] in1,
    input  logic [DATA_WIDTH-1:0] in2,
    output logic                  is_special,
    output logic [DATA_WIDTH-1:0] special_out
);

    logic [EXP_W-1:0]  exp1, exp2;
    logic [FRAC_W-1:0] frac1, frac2;
    logic              nan1, nan2, inf1, inf2, zero1, zero2, sign;

    assign exp1  = in1[DATA_WIDTH-2 -: EXP_W];
    assign exp2  = in2[DATA_WIDTH-2 -: EXP_W];
    assign frac1 = in1[FRAC_W-1:0];
    assign frac2 = in2[FRAC_W-1:0];
    assign sign  = in1[DATA_WIDTH-1] ^ in2[DATA_WIDTH-1];

    assign nan1  = (exp1 == {EXP_W{1'b1}}) && (frac1 != '0);
    assign nan2  = (exp2 == {EXP_W{1'b1}}) && (frac2 != '0);
    assign inf1  = (exp1 == {EXP_W{1'b1}}) && (frac1 == '0);
    assign inf2  = (exp2 == {EXP_W{1'b1}}) && (frac2 == '0);
    // A zero exponent covers both true zero and denormals, which are flushed.
    assign zero1 = (exp1 == '0);
    assign zero2 = (exp2 == '0);

    always_comb begin
        is_special  = 1'b1;
        special_out = '0;
        if (nan1 || nan2) begin
            special_out = QNAN;
        end else if ((inf1 && zero2) || (zero1 && inf2)) begin
            special_out = QNAN;
        end else if (inf1 || inf2) begin
            special_out = {sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
        end else if (zero1 || zero2) begin
            special_out = {sign, {(DATA_WIDTH-1){1'b0}}};
        end else begin
            is_special = 1'b0;
        end
    end

endmodule

// File: rtl/fp_mul_seq.sv
// Iterative IEEE-754 single-precision multiplier: radix-2 shift-add significand product
// (one bit per cycle), truncating normalisation, and a held result behind valid/ready.
module fp_mul_seq
    import fp_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in1,
    input  logic [DATA_WIDTH-1:0] in2,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out
);

    localparam logic signed [9:0] E_BIAS = 10'(EXP_BIAS);
    localparam logic signed [9:0] E_MAX  = 10'(EXP_MAX);

    state_e                    state_q, state_d;
    logic [MANT_W-1:0]         a_q, a_d, b_q, b_d;
    logic [2*MANT_W-1:0]       acc_q, acc_d;
    logic [4:0]                count_q, count_d;
    logic                      sign_q, sign_d, spec_q, spec_d;
    logic [EXP_W-1:0]          ea_q, ea_d, eb_q, eb_d;
    logic [DATA_WIDTH-1:0]     out_q, out_d;
    logic                      out_valid_q, out_valid_d;

    logic                      is_special;
    logic [DATA_WIDTH-1:0]     special_out;
    logic [MANT_W:0]           sum;
    logic signed [9:0]         e_raw, e_norm;
    logic [FRAC_W-1:0]         frac_norm;

    fp_mul_special #(.DATA_WIDTH(DATA_WIDTH)) u_special (
        .in1         (in1),
        .in2         (in2),
        .is_special  (is_special),
        .special_out (special_out)
    );

    function automatic logic [DATA_WIDTH-1:0] pack_result(
        input logic              sign,
        input logic signed [9:0] exp_v,
        input logic [FRAC_W-1:0] frac
    );
        if (exp_v >= E_MAX)
            return {sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
        else if (exp_v <= 10'sd0)
            return {sign, {(DATA_WIDTH-1){1'b0}}};
        else
            return {sign, exp_v[EXP_W-1:0], frac};
    endfunction

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign out       = out_q;

    // Single 24-bit adder: multiplicand into the accumulator's upper half, carry kept for the shift.
    always_comb begin
        sum       = {1'b0, acc_q[2*MANT_W-1:MANT_W]} + (b_q[0] ? {1'b0, a_q} : '0);
        e_raw     = $signed({2'b00, ea_q}) + $signed({2'b00, eb_q}) - E_BIAS;
        e_norm    = acc_q[2*MANT_W-1] ? e_raw + 10'sd1 : e_raw;
        frac_norm = acc_q[2*MANT_W-1] ? acc_q[2*MANT_W-2 -: FRAC_W]
                                      : acc_q[2*MANT_W-3 -: FRAC_W];
    end

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        acc_d       = acc_q;
        count_d     = count_q;
        sign_d      = sign_q;
        spec_d      = spec_q;
        ea_d        = ea_q;
        eb_d        = eb_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sign_d  = in1[DATA_WIDTH-1] ^ in2[DATA_WIDTH-1];
                    ea_d    = in1[DATA_WIDTH-2 -: EXP_W];
                    eb_d    = in2[DATA_WIDTH-2 -: EXP_W];
                    a_d     = {1'b1, in1[FRAC_W-1:0]};
                    b_d     = {1'b1, in2[FRAC_W-1:0]};
                    acc_d   = '0;
                    count_d = '0;
                    spec_d  = is_special;
                    // Special results are parked in the output register and published one cycle later via NORM.
                    if (is_special) begin
                        out_d   = special_out;
                        state_d = NORM;
                    end else begin
                        state_d = MUL;
                    end
                end
            end
            MUL: begin
                acc_d   = {sum, acc_q[MANT_W-1:1]};
                b_d     = b_q >> 1;
                count_d = count_q + 5'd1;
                if (count_q == 5'(MANT_W-1))
                    state_d = NORM;
            end
            NORM: begin
                if (!spec_q)
                    out_d = pack_result(sign_q, e_norm, frac_norm);
                out_valid_d = 1'b1;
                state_d     = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            acc_q       <= '0;
            count_q     <= '0;
            sign_q      <= 1'b0;
            spec_q      <= 1'b0;
            ea_q        <= '0;
            eb_q        <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            acc_q       <= acc_d;
            count_q     <= count_d;
            sign_q      <= sign_d;
            spec_q      <= spec_d;
            ea_q        <= ea_d;
            eb_q        <= eb_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_fp_mul_seq.sv
// Self-checking bench for fp_mul_seq: arithmetic reference model, per-cycle result compare,
// latency, backpressure and mid-operation reset scenarios.
module tb_fp_mul_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in1 = '0;
    logic [31:0] in2 = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out;

    int          n_pass = 0;
    int          n_tot = 0;
    logic [31:0] exp_q[$];

    fp_mul_seq #(.DATA_WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in1       (in1),
        .in2       (in2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation did not finish, %0d/%0d checks passed", n_pass, n_tot);
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tot++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%h, required 0x%h", name, act, req);
    endtask

    // Reference: exact integer significand product, truncate to 23 fraction bits.
    function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b);
        logic        s;
        int          ea, eb, e;
        logic [22:0] fa, fb, fr;
        logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
        longint unsigned p;
        s  = a[31] ^ b[31];
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        fa = a[22:0];
        fb = b[22:0];
        a_nan  = (ea == 255) && (fa != 0);
        b_nan  = (eb == 255) && (fb != 0);
        a_inf  = (ea == 255) && (fa == 0);
        b_inf  = (eb == 255) && (fb == 0);
        a_zero = (ea == 0);
        b_zero = (eb == 0);
        if (a_nan || b_nan) return 32'h7FC00000;
        if ((a_inf && b_zero) || (a_zero && b_inf)) return 32'h7FC00000;
        if (a_inf || b_inf) return {s, 8'hFF, 23'd0};
        if (a_zero || b_zero) return {s, 31'd0};
        p = 64'({1'b1, fa}) * 64'({1'b1, fb});
        e = ea + eb - 127;
        if (p >= (64'd1 << 47)) begin
            fr = 23'((p >> 24) & 64'h7FFFFF);
            e  = e + 1;
        end else begin
            fr = 23'((p >> 23) & 64'h7FFFFF);
        end
        if (e >= 255) return {s, 8'hFF, 23'd0};
        if (e <= 0) return {s, 31'd0};
        return {s, e[7:0], fr};
    endfunction

    // Every cycle a result is presented it must equal the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_out_valid", 32'(out_valid), 32'd0);
            end else begin
                chk("result", out, exp_q[0]);
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic accept(input logic [31:0] a, input logic [31:0] b);
        int t;
        t = 0;
        while (!in_ready && t < 100) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (t >= 100) chk("in_ready_timeout", 32'(in_ready), 32'd1);
        in1      = a;
        in2      = b;
        in_valid = 1'b1;
        @(posedge clk);
        exp_q.push_back(model(a, b));
        #1;
        in_valid = 1'b0;
        in1      = 32'hDEADBEEF;
        in2      = 32'h12345678;
        chk("accepted_in_ready_low", 32'(in_ready), 32'd0);
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!out_valid && n < 200);
    endtask

    task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] lit, input int lat);
        int n;
        chk({name, "_model"}, model(a, b), lit);
        out_ready = 1'b1;
        accept(a, b);
        wait_valid(n);
        chk({name, "_latency"}, 32'(n), 32'(lat));
        chk({name, "_out"}, out, lit);
        @(posedge clk);
        #1;
        chk({name, "_handshake_valid"}, 32'(out_valid), 32'd0);
        chk({name, "_handshake_ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        int n;
        #12;
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_out", out, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_op("mul_1p5x2",   32'h3FC00000, 32'h40000000, 32'h40400000, 25);
        run_op("mul_3x3",     32'h40400000, 32'h40400000, 32'h41100000, 25);
        run_op("mul_neg2x3",  32'hC0000000, 32'h40400000, 32'hC0C00000, 25);
        run_op("mul_7x5",     32'h40E00000, 32'h40A00000, 32'h420C0000, 25);
        run_op("sp_infx0",    32'h7F800000, 32'h00000000, 32'h7FC00000, 1);
        run_op("sp_nan",      32'h7FC00001, 32'h3F800000, 32'h7FC00000, 1);
        run_op("sp_neginf",   32'hFF800000, 32'h40000000, 32'hFF800000, 1);
        run_op("sp_negzero",  32'h80000000, 32'h40000000, 32'h80000000, 1);
        run_op("overflow",    32'h7F000000, 32'h7F000000, 32'h7F800000, 25);
        run_op("underflow",   32'h00800000, 32'h00800000, 32'h00000000, 25);
        run_op("denormal",    32'h00000001, 32'h3F800000, 32'h00000000, 1);

        // Backpressure: result held with out_ready low, then immediate re-accept.
        out_ready = 1'b0;
        accept(32'h3FC00000, 32'h40000000);
        wait_valid(n);
        chk("bp_latency", 32'(n), 32'd25);
        repeat (10) begin
            @(posedge clk);
            #1;
            chk("bp_out_stable", out, 32'h40400000);
            chk("bp_out_valid_held", 32'(out_valid), 32'd1);
            chk("bp_in_ready_low", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_release_in_ready", 32'(in_ready), 32'd1);
        run_op("after_bp", 32'h40400000, 32'h40400000, 32'h41100000, 25);

        // Asynchronous reset in the middle of the shift-add loop.
        accept(32'h40400000, 32'h40400000);
        repeat (10) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_out", out, 32'd0);
        exp_q.delete();
        #3;
        rst_n = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        chk("midrst_no_output", 32'(out_valid), 32'd0);
        run_op("post_rst_1p5x1p5", 32'h3FC00000, 32'h3FC00000, 32'h40100000, 25);

        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
